// File: rtl/menu_pkg.sv
// Shared battle-menu definitions used by the cursor controller, the game FSM
// and the cursor coordinate block.
package menu_pkg;

    localparam int N_ITEMS = 4;

    localparam logic [1:0] ITEM_FIGHT  = 2'd0;
    localparam logic [1:0] ITEM_ACTION = 2'd1;
    localparam logic [1:0] ITEM_ITEM   = 2'd2;
    localparam logic [1:0] ITEM_MERCY  = 2'd3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BROWSE   = 2'd1,
        CONFIRM  = 2'd2,
        COOLDOWN = 2'd3
    } menu_state_e;

    // Nearest enabled item in the given direction, wrapping; holds p when none is enabled.
    // Walking the distance from far to near lets the closest candidate win.
    function automatic logic [1:0] next_enabled(
        input logic [1:0]         p,
        input logic [N_ITEMS-1:0] mask,
        input logic               dir_right
    );
        logic [1:0] w_res;
        logic [1:0] w_cand;
        w_res = p;
        for (int k = N_ITEMS - 1; k >= 1; k--) begin
            w_cand = dir_right ? p + 2'(k) : p - 2'(k);
            if (mask[w_cand]) w_res = w_cand;
        end
        return w_res;
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Button level synchronizer followed by a registered rising-edge detector;
// emits one single-cycle pulse per press, SYNC_STAGES+1 cycles after the rise.
module btn_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_pulse
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_pulse;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync  <= '0;
            r_prev  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], i_btn};
            r_prev  <= r_sync[SYNC_STAGES-1];
            r_pulse <= r_sync[SYNC_STAGES-1] & ~r_prev;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/menu_cursor_ctrl.sv
// Battle-menu cursor sequencer: moves a 2-bit cursor over enabled items,
// issues a held select request to the game FSM, then cools down.
module menu_cursor_ctrl
    import menu_pkg::*;
#(
    parameter int RESET_POS   = 0,
    parameter int COOL_CYCLES = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_enable,
    input  logic         i_btn_left,
    input  logic         i_btn_right,
    input  logic         i_btn_select,
    input  logic [3:0]   i_item_mask,
    input  logic         i_select_ack,
    output logic [1:0]   o_cursor_position,
    output logic         o_select_valid,
    output logic [1:0]   o_select_item,
    output logic         o_busy
);

    localparam int CW = (COOL_CYCLES > 1) ? $clog2(COOL_CYCLES) : 1;

    logic [2:0]  w_pulse;
    logic        w_left, w_right, w_sel;

    menu_state_e r_state, w_state_nxt;
    logic [1:0]  r_pos, w_pos_nxt;
    logic [1:0]  r_item, w_item_nxt;
    logic        r_valid, w_valid_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic        w_busy;

    btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_btn [2:0] (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_btn   ({i_btn_select, i_btn_right, i_btn_left}),
        .o_pulse (w_pulse)
    );

    assign w_left  = w_pulse[0];
    assign w_right = w_pulse[1];
    assign w_sel   = w_pulse[2];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_pos   <= 2'(RESET_POS);
            r_item  <= 2'd0;
            r_valid <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pos   <= w_pos_nxt;
            r_item  <= w_item_nxt;
            r_valid <= w_valid_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!i_enable) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:     w_state_nxt = BROWSE;
                BROWSE:   if (w_sel && i_item_mask[r_pos]) w_state_nxt = CONFIRM;
                CONFIRM:  if (i_select_ack) w_state_nxt = COOLDOWN;
                COOLDOWN: if (r_cnt == '0) w_state_nxt = BROWSE;
                default:  w_state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        w_pos_nxt   = r_pos;
        w_item_nxt  = r_item;
        w_valid_nxt = r_valid;
        w_cnt_nxt   = r_cnt;
        w_busy      = (r_state == CONFIRM) || (r_state == COOLDOWN);
        if (!i_enable) begin
            w_valid_nxt = 1'b0;
        end else begin
            case (r_state)
                BROWSE: begin
                    // A select pulse suppresses any move, even when the select itself is refused.
                    if (w_sel) begin
                        if (i_item_mask[r_pos]) begin
                            w_item_nxt  = r_pos;
                            w_valid_nxt = 1'b1;
                        end
                    end else if (w_left ^ w_right) begin
                        w_pos_nxt = next_enabled(r_pos, i_item_mask, w_right);
                    end else if (!w_left && !i_item_mask[r_pos]) begin
                        w_pos_nxt = next_enabled(r_pos, i_item_mask, 1'b1);
                    end
                end
                CONFIRM: begin
                    if (i_select_ack) begin
                        w_valid_nxt = 1'b0;
                        w_cnt_nxt   = CW'(COOL_CYCLES - 1);
                    end
                end
                COOLDOWN: begin
                    if (r_cnt != '0) w_cnt_nxt = r_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_cursor_position = r_pos;
    assign o_select_valid    = r_valid;
    assign o_select_item     = r_item;
    assign o_busy            = w_busy;

endmodule

// File: tb/tb_menu_cursor_ctrl.sv
// Scoreboard bench for menu_cursor_ctrl: every change of the output tuple
// must match the next queued expectation, including its landing cycle.
module tb_menu_cursor_ctrl;

    typedef struct {
        string      name;
        logic [1:0] pos;
        logic       valid;
        logic [1:0] item;
        logic       busy;
        int         ecyc;
    } ev_t;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_enable = 1'b0;
    logic       i_btn_left = 1'b0;
    logic       i_btn_right = 1'b0;
    logic       i_btn_select = 1'b0;
    logic [3:0] i_item_mask = 4'b1111;
    logic       i_select_ack = 1'b0;
    logic [1:0] o_cursor_position;
    logic       o_select_valid;
    logic [1:0] o_select_item;
    logic       o_busy;

    menu_cursor_ctrl #(.RESET_POS(2), .COOL_CYCLES(16), .SYNC_STAGES(2)) dut (
        .i_clk             (i_clk),
        .i_rst_n           (i_rst_n),
        .i_enable          (i_enable),
        .i_btn_left        (i_btn_left),
        .i_btn_right       (i_btn_right),
        .i_btn_select      (i_btn_select),
        .i_item_mask       (i_item_mask),
        .i_select_ack      (i_select_ack),
        .o_cursor_position (o_cursor_position),
        .o_select_valid    (o_select_valid),
        .o_select_item     (o_select_item),
        .o_busy            (o_busy)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    ev_t        q[$];
    ev_t        mon_e;
    logic [5:0] mon_cur, mon_prev, mon_exp;
    int         n_chk = 0;
    int         n_pass = 0;
    bit         mon_on = 1'b0;

    task automatic push_ev(input string nm, input logic [1:0] p, input logic v,
                           input logic [1:0] it, input logic b, input int ec);
        ev_t e;
        e.name = nm; e.pos = p; e.valid = v; e.item = it; e.busy = b; e.ecyc = ec;
        q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic tap(input logic l, input logic r, input logic s);
        i_btn_left = l; i_btn_right = r; i_btn_select = s;
        tick(3);
        i_btn_left = 1'b0; i_btn_right = 1'b0; i_btn_select = 1'b0;
        tick(8);
    endtask

    task automatic chk_now(input string nm, input logic [5:0] exp);
        logic [5:0] got;
        got = {o_cursor_position, o_select_valid, o_select_item, o_busy};
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got pos=%0d valid=%0b item=%0d busy=%0b, expected pos=%0d valid=%0b item=%0d busy=%0b",
                      nm, got[5:4], got[3], got[2:1], got[0], exp[5:4], exp[3], exp[2:1], exp[0]);
    endtask

    initial begin
        fork
            begin : monitor
                forever begin
                    @(negedge i_clk);
                    mon_cur = {o_cursor_position, o_select_valid, o_select_item, o_busy};
                    if (mon_on && mon_cur !== mon_prev) begin
                        n_chk++;
                        if (q.size() == 0) begin
                            $display("FAIL unexpected_change: got pos=%0d valid=%0b item=%0d busy=%0b @cyc %0d, expected no change",
                                     mon_cur[5:4], mon_cur[3], mon_cur[2:1], mon_cur[0], cyc);
                        end else begin
                            mon_e = q.pop_front();
                            mon_exp = {mon_e.pos, mon_e.valid, mon_e.item, mon_e.busy};
                            if (mon_cur === mon_exp && (mon_e.ecyc < 0 || mon_e.ecyc == cyc)) n_pass++;
                            else $display("FAIL %s: got pos=%0d valid=%0b item=%0d busy=%0b @cyc %0d, expected pos=%0d valid=%0b item=%0d busy=%0b @cyc %0d",
                                          mon_e.name, mon_cur[5:4], mon_cur[3], mon_cur[2:1], mon_cur[0], cyc,
                                          mon_e.pos, mon_e.valid, mon_e.item, mon_e.busy, mon_e.ecyc);
                        end
                    end
                    mon_prev = mon_cur;
                end
            end
            begin : stimulus
                int s;
                tick(3);
                chk_now("reset_values", {2'd2, 1'b0, 2'd0, 1'b0});
                i_rst_n = 1'b1;
                mon_on  = 1'b1;
                tick(2);
                i_enable = 1'b1;
                tick(4);

                // Full mask: moves and both wraps, each landing 4 cycles after the rise
                push_ev("right_2to3", 2'd3, 0, 2'd0, 0, cyc + 4); tap(0, 1, 0);
                push_ev("right_wrap", 2'd0, 0, 2'd0, 0, cyc + 4); tap(0, 1, 0);
                push_ev("right_0to1", 2'd1, 0, 2'd0, 0, cyc + 4); tap(0, 1, 0);
                push_ev("left_1to0",  2'd0, 0, 2'd0, 0, cyc + 4); tap(1, 0, 0);
                push_ev("left_wrap",  2'd3, 0, 2'd0, 0, cyc + 4); tap(1, 0, 0);

                // Item 2 disabled
                i_item_mask = 4'b1011; tick(3);
                push_ev("m1011_right_3to0", 2'd0, 0, 2'd0, 0, cyc + 4); tap(0, 1, 0);
                push_ev("m1011_right_0to1", 2'd1, 0, 2'd0, 0, cyc + 4); tap(0, 1, 0);
                push_ev("m1011_skip2",      2'd3, 0, 2'd0, 0, cyc + 4); tap(0, 1, 0);
                push_ev("m1011_left_3to1",  2'd1, 0, 2'd0, 0, cyc + 4); tap(1, 0, 0);

                // All masked: nothing may move
                i_item_mask = 4'b0000; tick(3);
                tap(0, 1, 0); tap(1, 0, 0); tap(0, 0, 1);

                // Current item becomes masked: auto-advance right
                push_ev("auto_advance", 2'd2, 0, 2'd0, 0, cyc + 1);
                i_item_mask = 4'b1101; tick(4);
                push_ev("left_skip1", 2'd0, 0, 2'd0, 0, cyc + 4); tap(1, 0, 0);
                i_item_mask = 4'b1111; tick(3);

                // Select item 0, right ignored while waiting, ack after 5, 16-cycle cooldown
                s = cyc;
                push_ev("select_0", 2'd0, 1, 2'd0, 1, s + 4);
                i_btn_select = 1'b1;
                tick(2); i_btn_right = 1'b1;
                tick(7); i_select_ack = 1'b1;
                push_ev("ack_drop_valid", 2'd0, 0, 2'd0, 1, s + 10);
                push_ev("cooldown_end",   2'd0, 0, 2'd0, 0, s + 26);
                tick(1); i_select_ack = 1'b0; i_btn_select = 1'b0; i_btn_right = 1'b0;
                tick(2); i_btn_right = 1'b1;
                tick(3); i_btn_right = 1'b0;
                tick(12);
                push_ev("right_after_cool", 2'd1, 0, 2'd0, 0, cyc + 4); tap(0, 1, 0);

                // Simultaneous left+right, then select+right, ack on the cycle valid rises
                tap(1, 1, 0);
                push_ev("right_1to2", 2'd2, 0, 2'd0, 0, cyc + 4); tap(0, 1, 0);
                s = cyc;
                push_ev("select_wins", 2'd2, 1, 2'd2, 1, s + 4);
                i_btn_select = 1'b1; i_btn_right = 1'b1;
                tick(4); i_select_ack = 1'b1;
                push_ev("early_ack_drop", 2'd2, 0, 2'd2, 1, s + 5);
                push_ev("early_ack_cool", 2'd2, 0, 2'd2, 0, s + 21);
                tick(1); i_select_ack = 1'b0; i_btn_select = 1'b0; i_btn_right = 1'b0;
                tick(20);

                // Enable drop in CONFIRM, re-enable with select still held
                s = cyc;
                push_ev("select_2", 2'd2, 1, 2'd2, 1, s + 4);
                i_btn_select = 1'b1;
                tick(6); i_enable = 1'b0;
                push_ev("disable_abandon", 2'd2, 0, 2'd2, 0, s + 7);
                tick(3); i_enable = 1'b1;
                tick(12); i_btn_select = 1'b0;
                tick(8);

                // Async reset mid-COOLDOWN
                push_ev("right_2to3b", 2'd3, 0, 2'd2, 0, cyc + 4); tap(0, 1, 0);
                s = cyc;
                push_ev("select_3", 2'd3, 1, 2'd3, 1, s + 4);
                i_btn_select = 1'b1;
                tick(4); i_select_ack = 1'b1;
                push_ev("ack_3", 2'd3, 0, 2'd3, 1, s + 5);
                tick(1); i_select_ack = 1'b0; i_btn_select = 1'b0;
                tick(3);
                push_ev("async_reset_mon", 2'd2, 0, 2'd0, 0, -1);
                #2 i_rst_n = 1'b0;
                #1 chk_now("async_reset_now", {2'd2, 1'b0, 2'd0, 1'b0});
                tick(3);
                i_rst_n = 1'b1;
                tick(10);

                n_chk++;
                if (q.size() == 0) n_pass++;
                else $display("FAIL drain: got %0d events still pending, expected 0", q.size());
            end
        join_any
        disable fork;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/menu_cursor_ctrl.md
Name: menu_cursor_ctrl

Overview:
- Sequences the battle-menu cursor. Turns left/right/select button levels into a 2-bit cursor index that drives the cursor coordinate block: 0 = fight, 1 = action, 2 = item, 3 = mercy.
- Skips masked (unavailable) items and wraps around at either end.
- Issues a held select request to the game FSM, waits for acknowledge, then applies a cooldown.
- Sits between the button debouncers and the cursor/renderer; the game FSM consumes the select handshake.

Parameters:
- RESET_POS, 0, cursor index after reset (0..3).
- COOL_CYCLES, 16, input-ignore cycles after an acknowledged select (>=1).
- SYNC_STAGES, 2, synchronizer flops per button input (>=2).

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_enable  in  1  menu active; low forces IDLE.
- i_btn_left  in  1  left button level, asynchronous to i_clk.
- i_btn_right  in  1  right button level, asynchronous to i_clk.
- i_btn_select  in  1  select button level, asynchronous to i_clk.
- i_item_mask  in  4  bit k = 1 means item k is selectable.
- i_select_ack  in  1  game FSM accepts the select.
- o_cursor_position  out  2  current index, to the cursor block.
- o_select_valid  out  1  select request, held until ack.
- o_select_item  out  2  item being selected; stable while valid.
- o_busy  out  1  high in CONFIRM or COOLDOWN.

Behaviour:
- Clock and reset: one clock, i_clk. Reset is asynchronous and active-low on i_rst_n.
- Reset values: state IDLE, o_cursor_position = RESET_POS, o_select_valid = 0, o_select_item = 0, o_busy = 0, cooldown counter = 0, synchronizer and edge flops = 0.
- Input path: each button passes through SYNC_STAGES flops, then a rising-edge detector (one extra flop). A press pulse is one cycle wide, SYNC_STAGES+1 cycles after the input rises. A held button yields exactly one pulse.
- Next-enabled search:
  - Right: check p+1, p+2, p+3 (mod 4); take the first item whose mask bit is set.
  - Left: check p-1, p-2, p-3 (mod 4) the same way.
  - No enabled candidate: hold p.
  - Wrap: 3 -> 0 on right, 0 -> 3 on left.
- States:
  - IDLE: ignore presses. Go to BROWSE on the cycle after i_enable = 1.
  - BROWSE: a press pulse updates o_cursor_position on the following clock edge (press-to-position latency 1 cycle).
    - Left and right pulses in the same cycle: no move.
    - Select pulse with move pulse(s) in the same cycle: select wins, no move.
    - Select pulse with i_item_mask[p] = 1: latch o_select_item = p, set o_select_valid = 1 at the next edge, go to CONFIRM.
    - Select pulse with i_item_mask[p] = 0: ignored.
    - Current item masked and no press: auto-advance right to the next enabled item. Hold p if the mask is all zero.
  - CONFIRM: o_select_valid and o_select_item held; all presses ignored.
    - i_select_ack = 1: valid drops at the next edge; counter loads COOL_CYCLES-1; go to COOLDOWN.
    - i_select_ack = 1 on the same cycle valid first rises is legal and counts as an ack.
  - COOLDOWN: presses ignored; counter decrements each cycle. When counter = 0, go to BROWSE at the next edge, so exactly COOL_CYCLES cycles are spent in COOLDOWN.
- i_enable = 0 in any state: go to IDLE at the next edge and drop o_select_valid. A pending select is abandoned. o_cursor_position is retained. Edge-detect flops keep running, so a button already held on re-enable produces no pulse.
- o_busy = 1 exactly in CONFIRM and COOLDOWN.
- Mid-operation i_rst_n assertion: all outputs go to reset values immediately, without waiting for a clock edge.

Decomposition:
- Shared package (menu_pkg):
  - Item index constants: ITEM_FIGHT = 0, ITEM_ACTION = 1, ITEM_ITEM = 2, ITEM_MERCY = 3.
  - N_ITEMS = 4.
  - State encoding: IDLE, BROWSE, CONFIRM, COOLDOWN.
  - The same package is used by the game FSM and the cursor coordinate block.
- One sub-module: btn_sync_edge (parameter SYNC_STAGES), instanced three times. It does synchronizer plus rising-edge pulse and is reusable by the other button consumers.

Test Plan:
- Reset, then i_enable = 1 and mask = 4'b1111. Pulse right 3 times -> position 1, 2, 3. One more right -> 0 (wrap). Left from 0 -> 3. Each update lands SYNC_STAGES+2 = 4 cycles after the button rises.
- Mask = 4'b1011 (item disabled) at position 1. Right -> 3, skipping 2. Left -> 1. Mask = 4'b0000 -> position holds on any press.
- Position 0, select pressed -> o_select_valid = 1, o_select_item = 0, o_busy = 1. Right presses while waiting -> position stays 0.
  - Ack after 5 cycles -> valid low next edge. o_busy stays high 16 cycles, then a right press moves to 1.
- Left and right rise on the same cycle -> no move. Select and right rise on the same cycle at position 2 -> select of item 2, position stays 2.
- In CONFIRM, drop i_enable -> valid low next cycle, state IDLE, position retained. Re-enable with select still held -> no new select.
- Assert i_rst_n low mid-COOLDOWN with RESET_POS = 2 -> position 2, valid 0, busy 0 immediately, with no clock edge needed.
